student_iic_master_seq: RTL

- Hardware I2C master byte sequencer; replaces software bit-banging of the SCL/SDA pads with a command-driven engine.
- Accepts START / WRITE / READ / STOP commands over a valid/ready interface and generates the bus waveforms.
- Drives open-drain enables for the SCL and SDA iocell_bidir pads (output value tied 0 at top level) and samples the pad inputs.
- Sits between a TL-UL register front end (future wrapper) and the two pads.

---
 rtl/student_iic_master_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/student_iic_master_seq.sv
// Command-driven I2C master byte sequencer: START/WRITE/READ/STOP over valid/ready,
// open-drain SCL/SDA enables. Define STUDENT_IIC_CLK_STRETCH_EN to honour slave clock stretching.
module student_iic_master_seq #(
  parameter int QuarterDiv = 250,
  parameter int CntW       = $clog2(QuarterDiv)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_op_i,
  input  logic [7:0] cmd_data_i,
  input  logic       cmd_nack_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_nack_o,
  output logic       busy_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o
);
  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  typedef enum logic [2:0] {IDLE, START, BIT, STOP, DONE} state_e;

  state_e          state;
  logic [1:0]      op_q;
  logic [7:0]      data_q;
  logic            nack_q;
  logic [CntW-1:0] cnt;
  logic [1:0]      qph;
  logic [3:0]      bit_cnt;
  logic [8:0]      shreg;
  logic [1:0]      scl_sync, sda_sync;
  logic            scl_s, sda_s, hold, q_end;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end
  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];

`ifdef STUDENT_IIC_CLK_STRETCH_EN
  // Includes the synchronizer latency after SCL is released, so each stretchable phase
  // runs at least two cycles longer than nominal.
  assign hold = ~scl_s && (cnt == '0) &&
                (((state == BIT) && (qph == 2'd2)) ||
                 (((state == START) || (state == STOP)) && (qph == 2'd1)));
`else
  logic unused_scl;
  assign unused_scl = scl_s;
  assign hold       = 1'b0;
`endif

  assign q_end       = !hold && (cnt == CntW'(QuarterDiv - 1));
  assign cmd_ready_o = (state == IDLE);
  assign busy_o      = ~cmd_ready_o;

  // SDA enable for a data bit driven in Q0; bit 8 carries data[7], bit 0 is the ACK slot.
  function automatic logic bit_oe(logic [1:0] op, logic [7:0] d, logic n, logic [3:0] b);
    if (b == 4'd0) return (op == OP_READ) ? ~n : 1'b0;
    return (op == OP_WRITE) ? ~d[3'(b - 4'd1)] : 1'b0;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      op_q        <= OP_START;
      data_q      <= '0;
      nack_q      <= 1'b0;
      cnt         <= '0;
      qph         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      scl_oe_o    <= 1'b0;
      sda_oe_o    <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_nack_o  <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      if (state == START || state == BIT || state == STOP)
        cnt <= (hold || q_end) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (cmd_valid_i) begin
          op_q    <= cmd_op_i;
          data_q  <= cmd_data_i;
          nack_q  <= cmd_nack_i;
          cnt     <= '0;
          qph     <= '0;
          bit_cnt <= 4'd8;
          case (cmd_op_i)
            OP_START: begin
              state    <= START;
              sda_oe_o <= 1'b0;
            end
            OP_STOP: begin
              state    <= STOP;
              scl_oe_o <= 1'b1;
              sda_oe_o <= 1'b1;
            end
            default: begin
              state    <= BIT;
              scl_oe_o <= 1'b1;
              sda_oe_o <= bit_oe(cmd_op_i, cmd_data_i, cmd_nack_i, 4'd8);
            end
          endcase
        end
        START: if (q_end) begin
          qph <= qph + 2'd1;
          case (qph)
            2'd0:    scl_oe_o <= 1'b0;
            2'd1:    sda_oe_o <= 1'b1;
            2'd2:    scl_oe_o <= 1'b1;
            default: state    <= DONE;
          endcase
        end
        BIT: if (q_end) begin
          qph <= qph + 2'd1;
          case (qph)
            2'd0: ;
            2'd1: scl_oe_o <= 1'b0;
            2'd2: shreg    <= {shreg[7:0], sda_s};
            default: begin
              scl_oe_o <= 1'b1;
              if (bit_cnt == 4'd0) begin
                state <= DONE;
              end else begin
                bit_cnt  <= bit_cnt - 4'd1;
                sda_oe_o <= bit_oe(op_q, data_q, nack_q, bit_cnt - 4'd1);
              end
            end
          endcase
        end
        STOP: if (q_end) begin
          qph <= qph + 2'd1;
          case (qph)
            2'd0:    scl_oe_o <= 1'b0;
            2'd1:    sda_oe_o <= 1'b0;
            2'd2:    ;
            default: state    <= DONE;
          endcase
        end
        DONE: begin
          state <= IDLE;
          if (op_q == OP_WRITE || op_q == OP_READ) begin
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= (op_q == OP_READ) ? shreg[8:1] : 8'h00;
            rsp_nack_o  <= (op_q == OP_READ) ? nack_q : shreg[0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
